// File: rtl/rom_seq_pkg.sv
// Shared constants, state encoding and segment table for the ROM message sequencer.
package rom_seq_pkg;

  localparam int unsigned ADDR_W  = 6;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned NUM_SEG = 4;
  localparam int unsigned IDX_W   = 2;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t SEP_ADDR = 6'd47;

  // Inclusive address ranges of the stored segments: code, first name, second name, surname
  localparam addr_t SEG_START [NUM_SEG] = '{6'd0, 6'd9,  6'd15, 6'd29};
  localparam addr_t SEG_END   [NUM_SEG] = '{6'd8, 6'd14, 6'd21, 6'd36};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT,
    ST_SEND,
    ST_DONE
  } state_e;

  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_SEG-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_SEG) - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/rom_seg_picker.sv
// Combinational search for the next set mask bit strictly above the current segment index.
module rom_seg_picker
  import rom_seq_pkg::*;
(
  input  logic [NUM_SEG-1:0] mask_i,
  input  logic [IDX_W-1:0]   cur_idx_i,
  output logic [IDX_W-1:0]   nxt_idx_o,
  output logic               none_o
);

  always_comb begin
    nxt_idx_o = cur_idx_i;
    none_o    = 1'b1;
    // Descending scan so the lowest qualifying index is the one left standing
    for (int i = int'(NUM_SEG) - 1; i >= 0; i--) begin
      if (mask_i[i] && (i > int'(cur_idx_i))) begin
        nxt_idx_o = IDX_W'(i);
        none_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rom_msg_sequencer.sv
// Plays selected ROM text segments as a valid/ready byte stream.
// Optional separator insertion between segments: define ROM_SEQ_SEPARATOR_EN.
module rom_msg_sequencer
  import rom_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_SEG-1:0] seg_mask,
  input  logic               abort,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0]  rom_d,
  output logic [DATA_W-1:0]  char_out,
  output logic               char_valid,
  input  logic               char_ready,
  output logic               is_sep,
  output logic [IDX_W-1:0]   seg_idx,
  output logic               busy,
  output logic               done
);

  state_e              state_q, state_d;
  logic [NUM_SEG-1:0]  mask_q, mask_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  addr_t               addr_q, addr_d;
  logic                sep_q, sep_d;
  logic [DATA_W-1:0]   char_q, char_d;
  logic                valid_q, valid_d;
  logic                is_sep_q, is_sep_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [IDX_W-1:0]    nxt_idx;
  logic                nxt_none;
  logic                hs;
  logic                at_end;

  rom_seg_picker u_picker (
    .mask_i    (mask_q),
    .cur_idx_i (idx_q),
    .nxt_idx_o (nxt_idx),
    .none_o    (nxt_none)
  );

  assign hs     = (state_q == ST_SEND) && char_ready;
  assign at_end = (addr_q == SEG_END[idx_q]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = (seg_mask != '0) ? ST_ADDR : ST_DONE;
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_SEND;
      ST_SEND: if (hs) state_d = (sep_q || !at_end || !nxt_none) ? ST_ADDR : ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // Datapath and registered-output next values; abort suppresses any address step
  always_comb begin
    mask_d = mask_q;
    idx_d  = idx_q;
    addr_d = addr_q;
    sep_d  = sep_q;
    char_d = char_q;
    unique case (state_q)
      ST_IDLE: begin
        if (state_d == ST_ADDR) begin
          mask_d = seg_mask;
          idx_d  = lowest_set(seg_mask);
          addr_d = SEG_START[lowest_set(seg_mask)];
          sep_d  = 1'b0;
        end
      end
      ST_WAIT: char_d = rom_d;
      ST_SEND: begin
        if (hs && !abort) begin
          if (sep_q) begin
            idx_d  = nxt_idx;
            addr_d = SEG_START[nxt_idx];
            sep_d  = 1'b0;
          end else if (!at_end) begin
            addr_d = addr_q + ADDR_W'(1);
          end else if (!nxt_none) begin
`ifdef ROM_SEQ_SEPARATOR_EN
            addr_d = SEP_ADDR;
            sep_d  = 1'b1;
`else
            idx_d  = nxt_idx;
            addr_d = SEG_START[nxt_idx];
`endif
          end
        end
      end
      default: ;
    endcase
    if (abort) sep_d = 1'b0;

    valid_d = (state_d == ST_SEND);
    busy_d  = (state_d == ST_ADDR) || (state_d == ST_WAIT) || (state_d == ST_SEND);
    done_d  = (state_d == ST_DONE);
`ifdef ROM_SEQ_SEPARATOR_EN
    is_sep_d = (state_d == ST_SEND) && sep_d;
`else
    is_sep_d = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q   <= '0;
      idx_q    <= '0;
      addr_q   <= '0;
      sep_q    <= 1'b0;
      char_q   <= '0;
      valid_q  <= 1'b0;
      is_sep_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mask_q   <= mask_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      sep_q    <= sep_d;
      char_q   <= char_d;
      valid_q  <= valid_d;
      is_sep_q <= is_sep_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign rom_addr   = addr_q;
  assign char_out   = char_q;
  assign char_valid = valid_q;
  assign is_sep     = is_sep_q;
  assign seg_idx    = idx_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_rom_msg_sequencer.sv
// Self-checking bench: ROM model, vector table, reference stream model and corner sequences.
module tb_rom_msg_sequencer;

`ifdef ROM_SEQ_SEPARATOR_EN
  localparam bit SEP_EN = 1'b1;
`else
  localparam bit SEP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] seg_mask;
  logic       abort;
  logic [5:0] rom_addr;
  logic [7:0] rom_d;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       is_sep;
  logic [1:0] seg_idx;
  logic       busy;
  logic       done;

  rom_msg_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .seg_mask   (seg_mask),
    .abort      (abort),
    .rom_addr   (rom_addr),
    .rom_d      (rom_d),
    .char_out   (char_out),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .is_sep     (is_sep),
    .seg_idx    (seg_idx),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  logic [7:0] rom_mem [64];
  always @(posedge clk) rom_d <= rom_mem[rom_addr];

  typedef struct packed {
    logic [5:0] addr;
    logic [7:0] ch;
    logic       sep;
    logic [1:0] seg;
  } rec_t;

  typedef struct {
    logic [3:0] mask;
    int         n;
    logic [7:0] last;
    int         done_cyc;
  } vec_t;

  rec_t rx_q[$];
  rec_t exp_q[$];
  int   seg_lo [4] = '{0, 9, 15, 29};
  int   seg_hi [4] = '{8, 14, 21, 36};
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic put_str(input int base, input string s);
    for (int i = 0; i < s.len(); i++) rom_mem[base + i] = s[i];
  endtask

  // Reference stream: every selected segment in ascending order, optional separator between them
  task automatic build_exp(input logic [3:0] m);
    rec_t r;
    exp_q.delete();
    for (int s = 0; s < 4; s++) begin
      if (m[s]) begin
        for (int a = seg_lo[s]; a <= seg_hi[s]; a++) begin
          r.addr = 6'(a); r.ch = rom_mem[a]; r.sep = 1'b0; r.seg = 2'(s);
          exp_q.push_back(r);
        end
        if (SEP_EN && ((m >> (s + 1)) != 4'd0)) begin
          r.addr = 6'd47; r.ch = rom_mem[47]; r.sep = 1'b1; r.seg = 2'(s);
          exp_q.push_back(r);
        end
      end
    end
  endtask

  task automatic issue_start(input logic [3:0] m);
    start = 1'b1;
    seg_mask = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Runs from the first cycle after start until done or budget; records every handshake
  task automatic collect(input bit rand_ready, input int busy_start_cyc,
                         output int done_cyc, output bit saw_valid);
    bit         stall;
    logic [7:0] held;
    rec_t       r;
    rx_q.delete();
    done_cyc  = -1;
    saw_valid = 1'b0;
    stall     = 1'b0;
    held      = '0;
    for (int cyc = 1; cyc <= 3000; cyc++) begin
      if (stall) check("stall_hold", {31'd0, char_valid, char_out}, {31'd0, 1'b1, held});
      if (char_valid) saw_valid = 1'b1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc == busy_start_cyc) begin
        start = 1'b1;
        seg_mask = 4'b1000;
      end else begin
        start = 1'b0;
      end
      char_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (char_valid && char_ready) begin
        r.addr = rom_addr; r.ch = char_out; r.sep = is_sep; r.seg = seg_idx;
        rx_q.push_back(r);
      end
      stall = char_valid && !char_ready;
      held  = char_out;
      @(negedge clk);
    end
    start = 1'b0;
    if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_stream(input string name);
    int n;
    check({name, "_len"}, rx_q.size(), exp_q.size());
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_rec"}, 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  task automatic post_done;
    char_ready = 1'b1;
    @(negedge clk);
    check("done_pulse_width", {30'd0, done, busy}, 32'd0);
  endtask

  vec_t vecs [6];
  int   dc;
  bit   sv;
  bit   found;
  int   quiet;

  initial begin
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'h2E;
    put_str(0, "AB1234567");
    put_str(9, "JOANNA");
    put_str(15, "BEATRIX");
    put_str(29, "LAWRENCE");
    rom_mem[47] = 8'h7C;

    vecs[0] = '{4'b0001, 9, 8'h37, 28};
    vecs[1] = '{4'b1111, SEP_EN ? 33 : 30, 8'h45, SEP_EN ? 100 : 91};
    vecs[2] = '{4'b0101, SEP_EN ? 17 : 16, 8'h58, SEP_EN ? 52 : 49};
    vecs[3] = '{4'b0000, 0, 8'h00, 1};
    vecs[4] = '{4'b1000, 8, 8'h45, 25};
    vecs[5] = '{4'b0010, 6, 8'h41, 19};

    rst_n = 1'b0; start = 1'b0; seg_mask = '0; abort = 1'b0; char_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_addr_char", {18'd0, rom_addr, char_out}, 32'd0);
    check("reset_flags", {27'd0, char_valid, is_sep, busy, done, 1'b0}, 32'd0);
    check("reset_seg_idx", {30'd0, seg_idx}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      build_exp(vecs[v].mask);
      issue_start(vecs[v].mask);
      collect(1'b0, 0, dc, sv);
      compare_stream("vec_stream");
      check("vec_count", rx_q.size(), vecs[v].n);
      check("vec_done_cycle", dc, vecs[v].done_cyc);
      check("vec_busy_at_done", {31'd0, busy}, 32'd0);
      if (vecs[v].n > 0) check("vec_last_char", {24'd0, rx_q[rx_q.size() - 1].ch}, {24'd0, vecs[v].last});
      else               check("empty_no_valid", {31'd0, sv}, 32'd0);
      post_done();
    end

    for (int it = 0; it < 20; it++) begin
      logic [3:0] m;
      m = 4'($urandom_range(0, 15));
      build_exp(m);
      issue_start(m);
      collect(1'b1, 0, dc, sv);
      compare_stream("rand_stream");
      post_done();
    end

    build_exp(4'b0001);
    issue_start(4'b0001);
    collect(1'b0, 5, dc, sv);
    compare_stream("start_while_busy");
    post_done();

    // Abort at the third character of segment 2, handshake offered in the same cycle
    issue_start(4'b0110);
    found = 1'b0;
    for (int cyc = 0; cyc < 500 && !found; cyc++) begin
      char_ready = 1'b1;
      if (char_valid && seg_idx == 2'd2 && rom_addr == 6'd17) found = 1'b1;
      else @(negedge clk);
    end
    check("abort_reached", {31'd0, found}, 32'd1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", {29'd0, char_valid, busy, done}, 32'd0);
    quiet = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) quiet++;
      @(negedge clk);
    end
    check("abort_no_done", quiet, 32'd0);
    build_exp(4'b1000);
    issue_start(4'b1000);
    collect(1'b0, 0, dc, sv);
    compare_stream("after_abort");
    check("after_abort_done_cycle", dc, 32'd25);
    post_done();

    // Asynchronous reset while a character is stalled in SEND
    issue_start(4'b0001);
    char_ready = 1'b0;
    found = 1'b0;
    for (int cyc = 0; cyc < 50 && !found; cyc++) begin
      if (char_valid) found = 1'b1;
      else @(negedge clk);
    end
    check("send_reached", {31'd0, found}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_addr_char", {18'd0, rom_addr, char_out}, 32'd0);
    check("async_rst_flags", {26'd0, char_valid, is_sep, busy, done, seg_idx}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    char_ready = 1'b1;
    @(negedge clk);
    build_exp(4'b0010);
    issue_start(4'b0010);
    collect(1'b0, 0, dc, sv);
    compare_stream("after_reset");
    post_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
